pulse_stretch: RTL
==================

# pulse_stretch

Output-side conditioning block, the transmit-direction counterpart of the input debouncer. It converts single-cycle event strobes from core logic into pin-level pulses that slow external loads (LEDs, opto-couplers, scope triggers) can see. Every pulse has a guaranteed minimum high time and a guaranteed minimum low gap. Events that arrive while a pulse is in progress are queued in a saturating counter and replayed back-to-back, and an overflow is flagged sticky. It sits between core logic and an output pad.

## Interface
Parameters:
- HIGH_LEN, 6: cycles `o_sig` is held high per event; legal range ≥ 1.
- LOW_LEN, 6: minimum low cycles after each pulse; legal range ≥ 1.
- PEND_W, 2: width of the pending-event counter; maximum queued events = 2^PEND_W−1.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_evt  in  1  event strobe; each high cycle is one event.
- i_ovf_clr  in  1  clears `o_ovf`.
- o_sig  out  1  conditioned output to pad; registered.
- o_busy  out  1  high while the FSM is not IDLE; registered.
- o_ovf  out  1  sticky flag: an event was dropped; registered.

## Operation
- FSM states: IDLE, HIGH, GAP.
- Down-counter `cnt` has width $clog2(max(HIGH_LEN, LOW_LEN)+1).
- Pending counter `pend` has width PEND_W.
- IDLE, i_evt=1: go to HIGH; cnt ← HIGH_LEN−1.
- HIGH, cnt≠0: decrement cnt.
- HIGH, cnt=0: go to GAP; cnt ← LOW_LEN−1.
- GAP, cnt≠0: decrement cnt.
- GAP, cnt=0, when any of the following holds, go to HIGH with cnt ← HIGH_LEN−1:
  - pend>0: pend is decremented, unless i_evt also fires, in which case pend is unchanged.
  - pend=0 and i_evt=1: the event is consumed directly.
- GAP, cnt=0, otherwise: go to IDLE.
- i_evt in HIGH, or in GAP with cnt≠0: pend is incremented.
- Saturation: if i_evt arrives while pend is already 2^PEND_W−1, pend stays unchanged and o_ovf ← 1.
- o_ovf is sticky and cleared only by i_ovf_clr or i_rst. If an overflow event and i_ovf_clr occur in the same cycle, set wins.
- o_sig = 1 exactly while the state is HIGH. The output is registered, so it is glitch-free by construction.
- o_busy = 1 while the state is not IDLE.

## Timing
- Reset values: o_sig=0, o_busy=0, o_ovf=0, state=IDLE, pend=0, cnt=0.
- Reset takes effect at the first rising edge with i_rst=1, from any state, including mid-pulse. All pending events are discarded.
- Latency: i_evt sampled at edge t in IDLE gives o_sig=1 from cycle t+1 through t+HIGH_LEN.
- Following low gap: cycles t+HIGH_LEN+1 through t+HIGH_LEN+LOW_LEN.
- Period of back-to-back pulses from the queue: exactly HIGH_LEN+LOW_LEN cycles. There are no idle bubbles between a GAP and the next HIGH.
- i_evt held high for N cycles counts as N events; no edge detection is performed.
- Arithmetic: all counters are unsigned. pend never wraps in either direction.

## Structure
- `io_cond_pkg` holds:
  - the `pstretch_state_e` enum (IDLE, HIGH, GAP), 2-bit encoding;
  - shared `cnt_w()` helper function used with the debouncer.
- No sub-module. The pending counter is inline; it is too small to justify a separate saturating-counter block.

## Test plan
All scenarios use HIGH_LEN=4, LOW_LEN=3, PEND_W=2, with reset released before cycle 5.
- Single i_evt at cycle 10:
  - o_sig=1 on cycles 11–14, 0 on 15–17.
  - o_busy=1 on 11–17, 0 at 18.
  - o_ovf=0.
- i_evt on cycles 10, 11, 12:
  - pulses on cycles 11–14, 18–21 and 25–28.
  - o_busy stays high continuously through 31.
- i_evt on cycles 10–14 (5 events):
  - pend saturates at 3 on cycle 13.
  - o_ovf=1 from cycle 15 and holds.
  - exactly 4 pulses are emitted.
  - i_ovf_clr at cycle 40 gives o_ovf=0 at 41.
- pend=0, i_evt on the last GAP cycle (cycle 17 after an event at 10):
  - o_sig=1 on cycles 18–21, with no IDLE cycle between pulses.
- i_rst=1 at cycle 12, mid-HIGH, with pend=2:
  - o_sig=0, o_busy=0, o_ovf=0 at 13.
  - no further pulses without a new i_evt.
- i_ovf_clr and an overflowing i_evt in the same cycle: o_ovf remains 1.

Source files
------------

// File: rtl/io_cond_pkg.sv
// Shared types and helpers for the pad-side I/O conditioning blocks.
// Used by pulse_stretch and by the input debouncer.
package io_cond_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pstretch_state_e;

  // Width of a down-counter that must hold the larger of two lengths.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into pad pulses with a minimum
// high time and low gap; events arriving mid-pulse are queued and replayed.
module pulse_stretch
  import io_cond_pkg::*;
#(
  parameter int HIGH_LEN = 6,
  parameter int LOW_LEN  = 6,
  parameter int PEND_W   = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_evt,
  input  logic i_ovf_clr,
  output logic o_sig,
  output logic o_busy,
  output logic o_ovf
);

  localparam int CW = cnt_w(HIGH_LEN, LOW_LEN);
  localparam logic [CW-1:0] H_LD = CW'(HIGH_LEN - 1);
  localparam logic [CW-1:0] L_LD = CW'(LOW_LEN - 1);
  localparam logic [PEND_W-1:0] P_MAX = '1;

  pstretch_state_e   state;
  logic [CW-1:0]     cnt;
  logic [PEND_W-1:0] pend;

  logic cnt_zero;
  logic queue_evt;
  logic sat;
  logic pend_nz;

  assign cnt_zero  = (cnt == '0);
  assign pend_nz   = (pend != '0);
  assign sat       = (pend == P_MAX);
  // The last GAP cycle hands i_evt straight to the next pulse instead.
  assign queue_evt = i_evt &&
                     ((state == HIGH) || ((state == GAP) && !cnt_zero));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= '0;
      o_sig  <= 1'b0;
      o_busy <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      if (queue_evt && !sat) begin
        pend <= pend + 1'b1;
      end

      if (queue_evt && sat) begin
        o_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        o_ovf <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (i_evt) begin
            state  <= HIGH;
            cnt    <= H_LD;
            o_sig  <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        HIGH: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= GAP;
            cnt   <= L_LD;
            o_sig <= 1'b0;
          end
        end
        GAP: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (pend_nz || i_evt) begin
            state <= HIGH;
            cnt   <= H_LD;
            o_sig <= 1'b1;
            if (pend_nz && !i_evt) begin
              pend <= pend - 1'b1;
            end
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          o_sig  <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
